// File: rtl/beta_issue_arbiter_pkg.sv
// beta_issue_arbiter_pkg
//   Shared types and constants for the Beta issue arbiter slice.
//   inst_reg    : instruction word layout {op, src1, src2, dest, unused}
//   BETA_NOP    : bubble instruction driven when nothing issues
//   BETA_R31    : register that never participates in a RAW hazard
//   arb_state_e : issue-stage FSM states
package beta_issue_arbiter_pkg;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic [4:0]  dest;
        logic [10:0] unused;
    } inst_reg;

    localparam logic [31:0] BETA_NOP = 32'h0000_0000;
    localparam logic [4:0]  BETA_R31 = 5'd31;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD_ST
    } arb_state_e;

endpackage

// File: rtl/beta_issue_arbiter_rr.sv
// beta_rr_arbiter
//   Purely combinational round-robin picker. Scans the request vector
//   starting at ptr and wrapping modulo NREQ; the first set bit wins.
// Ports
//   req  in  NREQ          request vector
//   ptr  in  $clog2(NREQ)  index that has highest priority this cycle
//   gnt  out NREQ          one-hot winner (all zero when no request)
//   idx  out $clog2(NREQ)  binary index of the winner (0 when none)
//   any  out 1             at least one request present
module beta_rr_arbiter
    import beta_issue_arbiter_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);

    localparam int IDX_W = $clog2(NREQ);

    always_comb begin
        logic [IDX_W-1:0] cand;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand = IDX_W'((32'(ptr) + off) % NREQ);
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/beta_issue_arbiter.sv
// beta_issue_arbiter
//   Shares the Beta DUT instruction port among NREQ stimulus sources.
//   Round-robin arbitration, one registered instruction per cycle, freezes
//   on HOLD. Optional RAW interlock enabled by defining BETA_ARB_HAZARD_EN:
//   a winner whose src1/src2 (other than R31) matches any of the last
//   HAZ_DEPTH issued destinations is stalled and a bubble is issued instead.
// Ports
//   CLK          in   1              clock, posedge
//   RST          in   1              synchronous reset, active-high
//   req_valid    in   NREQ           requester i has an instruction
//   req_instr    in   32*NREQ        requester i instruction at [32*i +: 32]
//   req_ready    out  NREQ           one-hot grant, transfer on valid && ready
//   HOLD         in   1              DUT back-pressure, freezes the issue stage
//   INSTR        out  32             registered instruction to the DUT
//   INSTR_VALID  out  1              INSTR is a real instruction
//   grant_id     out  $clog2(NREQ)   requester that produced the last issue
//   issue_cnt    out  CNT_W          real instructions issued, wraps
module beta_issue_arbiter
    import beta_issue_arbiter_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int HAZ_DEPTH = 3,
    parameter int CNT_W     = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [32*NREQ-1:0]      req_instr,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    HOLD,
    output logic [31:0]             INSTR,
    output logic                    INSTR_VALID,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic [CNT_W-1:0]        issue_cnt
);

    localparam int IDX_W = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("beta_issue_arbiter: NREQ must be 2..8");
    end
    if (HAZ_DEPTH < 1 || HAZ_DEPTH > 4) begin : g_bad_haz
        $error("beta_issue_arbiter: HAZ_DEPTH must be 1..4");
    end

    arb_state_e       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] win_idx;
    logic [NREQ-1:0]  win_gnt;
    logic             win_any;
    inst_reg          win_f;
    inst_reg          instr_q;
    logic             stall;
    logic             accept;

    beta_rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (win_gnt),
        .idx (win_idx),
        .any (win_any)
    );

    // Winner's instruction word.
    always_comb begin
        win_f = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_f = inst_reg'(req_instr[32*i +: 32]);
            end
        end
    end

    // HOLD and a hazard stall both take precedence over a pending request.
    assign accept    = !RST && !HOLD && win_any && !stall;
    assign req_ready = accept ? win_gnt : '0;
    assign INSTR     = instr_q;

`ifdef BETA_ARB_HAZARD_EN
    // Destinations of the last HAZ_DEPTH issue slots, newest at index 0.
    // Bubbles push R31 so the window drains while a consumer is stalled.
    logic [HAZ_DEPTH-1:0][4:0] window;
    logic [4:0]                push_dest;

    always_comb begin
        stall = 1'b0;
        if (win_any) begin
            for (int unsigned d = 0; d < HAZ_DEPTH; d++) begin
                if ((win_f.src1 != BETA_R31 && win_f.src1 == window[d]) ||
                    (win_f.src2 != BETA_R31 && win_f.src2 == window[d])) begin
                    stall = 1'b1;
                end
            end
        end
    end

    assign push_dest = accept ? win_f.dest : BETA_R31;

    always_ff @(posedge CLK) begin
        if (RST) begin
            window <= '1;
        end else if (!HOLD) begin
            window[0] <= push_dest;
            for (int unsigned d = 1; d < HAZ_DEPTH; d++) begin
                window[d] <= window[d-1];
            end
        end
    end
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            instr_q     <= inst_reg'(BETA_NOP);
            INSTR_VALID <= 1'b0;
            grant_id    <= '0;
            issue_cnt   <= '0;
            rr_ptr      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (HOLD)         state <= HOLD_ST;
                    else if (win_any) state <= ISSUE;
                end
                ISSUE: begin
                    if (HOLD)          state <= HOLD_ST;
                    else if (!win_any) state <= IDLE;
                end
                HOLD_ST: begin
                    if (!HOLD) state <= win_any ? ISSUE : IDLE;
                end
                default: state <= IDLE;
            endcase

            if (!HOLD) begin
                if (accept) begin
                    instr_q     <= win_f;
                    INSTR_VALID <= 1'b1;
                    grant_id    <= win_idx;
                    issue_cnt   <= issue_cnt + 1'b1;
                    rr_ptr      <= (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                end else begin
                    instr_q     <= inst_reg'(BETA_NOP);
                    INSTR_VALID <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_beta_issue_arbiter.sv
module tb_beta_issue_arbiter;

    localparam int NREQ = 4;
    localparam int HAZ  = 3;
    localparam int CW   = 4;
`ifdef BETA_ARB_HAZARD_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    logic                 CLK = 1'b0;
    logic                 RST = 1'b1;
    logic                 HOLD = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [32*NREQ-1:0]   req_instr = '0;
    logic [NREQ-1:0]      req_ready;
    logic [31:0]          INSTR;
    logic                 INSTR_VALID;
    logic [1:0]           grant_id;
    logic [CW-1:0]        issue_cnt;

    always #5 CLK = ~CLK;

    beta_issue_arbiter #(
        .NREQ      (NREQ),
        .HAZ_DEPTH (HAZ),
        .CNT_W     (CW)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .req_valid   (req_valid),
        .req_instr   (req_instr),
        .req_ready   (req_ready),
        .HOLD        (HOLD),
        .INSTR       (INSTR),
        .INSTR_VALID (INSTR_VALID),
        .grant_id    (grant_id),
        .issue_cnt   (issue_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] s1,
                                       input logic [4:0] s2, input logic [4:0] d,
                                       input logic [10:0] tag);
        return {op, s1, s2, d, tag};
    endfunction

    // ---------------- requester queues / driver ----------------
    logic [31:0]     q [NREQ][$];
    logic [NREQ-1:0] fire = '0;

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (fire[i]) void'(q[i].pop_front());
                req_valid[i]          = (q[i].size() != 0);
                req_instr[32*i +: 32] = (q[i].size() != 0) ? q[i][0] : 32'h0;
            end
        end
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    logic [31:0] m_instr;
    bit          m_valid;
    int          m_gid, m_cnt, m_ptr;
    int          m_win[$];
    bit          armed = 1'b0;
    int          cyc = 0;
    bit          last_frozen = 1'b1;
    bit [NREQ-1:0] pend = '0;
    logic [31:0] pend_instr [NREQ];

    int          lg_gid[$];
    logic [31:0] lg_instr[$];
    int          lg_cyc[$];
    int          lg_cnt[$];

    function automatic bit blocked(input logic [31:0] x);
        int s1, s2;
        s1 = int'(x[25:21]);
        s2 = int'(x[20:16]);
        foreach (m_win[k]) begin
            if ((s1 != 31 && s1 == m_win[k]) || (s2 != 31 && s2 == m_win[k])) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic push_win(input int d);
        m_win.push_front(d);
        while (m_win.size() > HAZ) void'(m_win.pop_back());
    endtask

    always @(negedge CLK) begin : compare
        int w;
        bit acc;
        logic [NREQ-1:0] er;
        logic [31:0] wi;
        cyc++;
        w  = -1;
        wi = '0;
        for (int off = 0; off < NREQ; off++) begin
            int i;
            i = (m_ptr + off) % NREQ;
            if (w < 0 && req_valid[i] === 1'b1) w = i;
        end
        acc = (RST === 1'b0) && (HOLD === 1'b0) && (w >= 0);
        if (w >= 0) wi = req_instr[32*w +: 32];
        if (acc && HZ && blocked(wi)) acc = 1'b0;
        er = '0;
        if (acc) er[w] = 1'b1;

        if (armed) begin
            chk("instr",     INSTR,       m_instr);
            chk("valid",     INSTR_VALID, m_valid);
            chk("grant_id",  grant_id,    m_gid);
            chk("issue_cnt", issue_cnt,   m_cnt);
            chk("req_ready", req_ready,   er);
            if (INSTR_VALID === 1'b1 && !last_frozen) begin
                lg_gid.push_back(int'(grant_id));
                lg_instr.push_back(INSTR);
                lg_cyc.push_back(cyc);
                lg_cnt.push_back(int'(issue_cnt));
            end
        end
        last_frozen = (RST !== 1'b0) || (HOLD !== 1'b0);

        for (int i = 0; i < NREQ; i++) begin
            if (pend[i]) begin
                assert (req_valid[i] === 1'b1 && req_instr[32*i +: 32] === pend_instr[i])
                    else $error("requester %0d dropped or changed a pending request", i);
            end
            pend[i]       = (req_valid[i] === 1'b1) && (req_ready[i] !== 1'b1);
            pend_instr[i] = req_instr[32*i +: 32];
        end
        fire = req_valid & req_ready;

        if (RST !== 1'b0) begin
            m_instr = 32'h0; m_valid = 1'b0; m_gid = 0; m_cnt = 0; m_ptr = 0;
            m_win = {};
            for (int k = 0; k < HAZ; k++) m_win.push_back(31);
            armed = 1'b1;
        end else if (HOLD === 1'b0) begin
            if (acc) begin
                m_instr = wi;
                m_valid = 1'b1;
                m_gid   = w;
                m_cnt   = (m_cnt + 1) % (1 << CW);
                m_ptr   = (w + 1) % NREQ;
                push_win(int'(wi[15:11]));
            end else begin
                m_instr = 32'h0;
                m_valid = 1'b0;
                push_win(31);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic drain(input string tag);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge CLK);
            #1;
            done = (req_valid == '0);
            for (int i = 0; i < NREQ; i++) if (q[i].size() != 0) done = 1'b0;
        end
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL drain_%s: requests still pending after 100 cycles, required empty", tag);
        end
    endtask

    task automatic wait_log(input int n);
        for (int c = 0; c < 100 && lg_gid.size() < n; c++) begin
            @(negedge CLK);
            #1;
        end
        if (lg_gid.size() < n) begin
            n_chk++; n_fail++;
            $display("FAIL wait_log: actual %0d issues required %0d", lg_gid.size(), n);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin : stim
        logic [31:0] a_ins, b_ins, c_ins, d_ins, held;
        logic [CW-1:0] held_cnt;

        // Reset with every requester valid.
        for (int i = 0; i < NREQ; i++) begin
            q[i].push_back(mk(6'h01, 5'd31, 5'd31, 5'd31, 11'(16 + i)));
            q[i].push_back(mk(6'h01, 5'd31, 5'd31, 5'd31, 11'(32 + i)));
        end
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_instr", INSTR, 32'h0);
        chk("rst_valid", INSTR_VALID, 1'b0);
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_cnt",   issue_cnt, 4'd0);
        @(posedge CLK);
        #1 RST = 1'b0;

        // Fairness: all valid, 8 issues in order 0,1,2,3,0,1,2,3.
        drain("fair");
        chk("fair_n",   lg_gid.size(), 8);
        chk("fair_cnt", issue_cnt, 4'd8);
        for (int k = 0; k < 8; k++) chk("fair_gid", lg_gid[k], k % 4);
        chk("fair_first", lg_instr[0], 32'h07FF_F810);

        // HOLD for 5 cycles mid-stream.
        idle(4);
        for (int i = 0; i < NREQ; i++) begin
            q[i].push_back(mk(6'h02, 5'd31, 5'd31, 5'd31, 11'(48 + i)));
            q[i].push_back(mk(6'h02, 5'd31, 5'd31, 5'd31, 11'(64 + i)));
        end
        wait_log(10);
        @(posedge CLK);
        #1 HOLD = 1'b1;
        @(negedge CLK);
        held     = INSTR;
        held_cnt = issue_cnt;
        repeat (4) @(negedge CLK);
        chk("hold_instr", INSTR, held);
        chk("hold_cnt",   issue_cnt, held_cnt);
        chk("hold_ready", req_ready, 4'b0000);
        @(posedge CLK);
        #1 HOLD = 1'b0;
        drain("hold");
        chk("hold_n",   lg_gid.size(), 16);
        chk("hold_cnt_wrap", issue_cnt, 4'd0);
        for (int k = 8; k < 16; k++) chk("hold_gid", lg_gid[k], k % 4);

        // RAW hazard: req0 writes r3, req1 reads r3.
        idle(4);
        a_ins = mk(6'h20, 5'd31, 5'd31, 5'd3, 11'h0A);
        b_ins = mk(6'h10, 5'd3,  5'd31, 5'd5, 11'h0B);
        q[0].push_back(a_ins);
        q[1].push_back(b_ins);
        drain("haz");
        chk("haz_a",   lg_instr[16], a_ins);
        chk("haz_b",   lg_instr[17], b_ins);
        chk("haz_gap", lg_cyc[17] - lg_cyc[16], HZ ? 4 : 1);
        chk("wrap17",  lg_cnt[16], 1);

        // R31 never interlocks.
        idle(4);
        c_ins = mk(6'h21, 5'd31, 5'd31, 5'd31, 11'h0C);
        d_ins = mk(6'h11, 5'd31, 5'd31, 5'd7,  11'h0D);
        q[0].push_back(c_ins);
        q[1].push_back(d_ins);
        drain("r31");
        chk("r31_c",   lg_instr[18], c_ins);
        chk("r31_d",   lg_instr[19], d_ins);
        chk("r31_gap", lg_cyc[19] - lg_cyc[18], 1);

        // Sparse single requester 2 with bubbles in between.
        for (int k = 0; k < 3; k++) begin
            idle(2);
            q[2].push_back(mk(6'h30, 5'd31, 5'd31, 5'd31, 11'(80 + k)));
            drain("sparse");
        end
        idle(3);
        for (int k = 20; k < 23; k++) chk("sparse_gid", lg_gid[k], 2);
        chk("sparse_gap", lg_cyc[21] - lg_cyc[20] > 1, 1'b1);
        chk("end_gid",   grant_id, 2'd2);
        chk("end_valid", INSTR_VALID, 1'b0);
        chk("end_instr", INSTR, 32'h0);
        chk("end_cnt",   issue_cnt, 4'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
